audio_i2s_tx: RTL and testbench

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

---
 rtl/audio_i2s_tx.sv | 93 +++++++++
 tb/tb_audio_i2s_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// I2S-style (left-justified) stereo transmitter: 512-clk frames, 16 bits per channel, MSB first.
// Optional SAT_GAIN_EN macro adds a 2-bit gain port with saturating left shift at sample latch time.
module audio_i2s_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] audio_left,
  input  logic [15:0] audio_right,
  input  logic        mute,
`ifdef SAT_GAIN_EN
  input  logic [1:0]  gain,
`endif
  output logic        audio_mclk,
  output logic        audio_lrck,
  output logic        audio_sck,
  output logic        audio_sdin,
  output logic        sample_req
);

  localparam logic [8:0] LAST_CNT = 9'd511;

  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] hold_l_q, hold_l_d;
  logic [15:0] hold_r_q, hold_r_d;
  logic        sdin_q, sdin_d;
  logic        req_q, req_d;
  logic [15:0] lat_l, lat_r;
  logic [15:0] tx_word;

`ifdef SAT_GAIN_EN
  // Shift in a 19-bit signed domain so any gain 0..3 fits before clamping.
  function automatic logic [15:0] sat_shift(input logic [15:0] s, input logic [1:0] g);
    logic signed [18:0] ext;
    ext = $signed({{3{s[15]}}, s}) <<< g;
    if (ext > 19'sd32767)       sat_shift = 16'h7FFF;
    else if (ext < -19'sd32768) sat_shift = 16'h8000;
    else                        sat_shift = ext[15:0];
  endfunction
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
`ifdef SAT_GAIN_EN
    lat_l = sat_shift(audio_left, gain);
    lat_r = sat_shift(audio_right, gain);
`else
    lat_l = audio_left;
    lat_r = audio_right;
`endif
    if (mute) begin
      lat_l = 16'h0000;
      lat_r = 16'h0000;
    end
  end

  always_comb begin
    cnt_d    = cnt_q + 9'd1;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    req_d    = (cnt_q == LAST_CNT);
    if (cnt_q == LAST_CNT) begin
      hold_l_d = lat_l;
      hold_r_d = lat_r;
    end
    // Serial bit is derived from the next count and next hold words so the
    // registered output lines up with the count it belongs to.
    tx_word = cnt_d[8] ? hold_r_d : hold_l_d;
    sdin_d  = tx_word[4'd15 - cnt_d[7:4]];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      sdin_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      sdin_q   <= sdin_d;
      req_q    <= req_d;
    end
  end

  assign audio_mclk = cnt_q[1];
  assign audio_sck  = cnt_q[3];
  assign audio_lrck = cnt_q[8];
  assign audio_sdin = sdin_q;
  assign sample_req = req_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: reset/clock timing, table of latched words, mid-frame and reset corner cases.
// Build with +define+SAT_GAIN_EN to exercise the saturating gain vectors.
module tb_audio_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] audio_left = 16'h0000;
  logic [15:0] audio_right = 16'h0000;
  logic        mute = 1'b0;
  logic [1:0]  gain = 2'd0;
  logic        audio_mclk, audio_lrck, audio_sck, audio_sdin, sample_req;

  audio_i2s_tx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .mute       (mute),
`ifdef SAT_GAIN_EN
    .gain       (gain),
`endif
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_sdin (audio_sdin),
    .sample_req (sample_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] left;
    logic [15:0] right;
    logic        mute;
    logic [1:0]  gain;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at the negedge where rst_n has just been released (count 0).
  task automatic check_release();
    logic [8:0] c;
    for (int n = 0; n < 512; n++) begin
      c = n[8:0];
      check($sformatf("post-reset cycle %0d {mclk,sck,lrck,req,sdin}", n),
            {27'd0, audio_mclk, audio_sck, audio_lrck, sample_req, audio_sdin},
            {27'd0, c[1], c[3], c[8], 1'b0, 1'b0});
      @(negedge clk);
    end
  endtask

  // Called at the negedge where sample_req is high; captures one whole frame
  // at the sck-high midpoints and ends on the next frame's first negedge.
  task automatic capture(input int change_at, input logic [15:0] new_left,
                         output logic [15:0] l, output logic [15:0] r);
    logic [8:0] c;
    logic       bad_req;
    logic       bad_clk;
    bad_req = 1'b0;
    bad_clk = 1'b0;
    l = 16'h0000;
    r = 16'h0000;
    check("frame start sample_req", {31'd0, sample_req}, 32'd1);
    for (int n = 0; n < 512; n++) begin
      c = n[8:0];
      if (n == change_at) audio_left = new_left;
      if (c[3:0] == 4'd8) begin
        if (c[8]) r[4'd15 - c[7:4]] = audio_sdin;
        else      l[4'd15 - c[7:4]] = audio_sdin;
      end
      if (n != 0 && sample_req !== 1'b0) bad_req = 1'b1;
      if (audio_lrck !== c[8] || audio_sck !== c[3] || audio_mclk !== c[1]) bad_clk = 1'b1;
      @(negedge clk);
    end
    check("sample_req idle inside frame", {31'd0, bad_req}, 32'd0);
    check("clock outputs inside frame", {31'd0, bad_clk}, 32'd0);
  endtask

  logic [15:0] got_l, got_r;

  initial begin
    vecs.push_back('{16'hA5C3, 16'h0F0F, 1'b0, 2'd0, 16'hA5C3, 16'h0F0F});
    vecs.push_back('{16'h1234, 16'h8001, 1'b0, 2'd0, 16'h1234, 16'h8001});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b0, 2'd0, 16'hFFFF, 16'h0000});
    vecs.push_back('{16'h8000, 16'h7FFF, 1'b0, 2'd0, 16'h8000, 16'h7FFF});
    vecs.push_back('{16'hA5C3, 16'h0F0F, 1'b1, 2'd0, 16'h0000, 16'h0000});
`ifdef SAT_GAIN_EN
    vecs.push_back('{16'h3000, 16'h0001, 1'b0, 2'd2, 16'h7FFF, 16'h0004});
    vecs.push_back('{16'hF000, 16'hFFFF, 1'b0, 2'd2, 16'hC000, 16'hFFFC});
    vecs.push_back('{16'h1000, 16'h9000, 1'b0, 2'd1, 16'h2000, 16'h8000});
    vecs.push_back('{16'h3000, 16'h9000, 1'b1, 2'd3, 16'h0000, 16'h0000});
`else
    vecs.push_back('{16'h3000, 16'h9000, 1'b0, 2'd3, 16'h3000, 16'h9000});
`endif

    // Reset held for 5 cycles with live data on the inputs.
    audio_left  = 16'hA5C3;
    audio_right = 16'h0F0F;
    repeat (5) @(negedge clk);
    check("outputs during reset", {27'd0, audio_mclk, audio_sck, audio_lrck, sample_req, audio_sdin}, 32'd0);
    rst_n = 1'b1;
    check_release();

    // Second frame after release carries the held inputs.
    capture(-1, 16'h0000, got_l, got_r);
    check("second frame left", {16'd0, got_l}, 32'h0000A5C3);
    check("second frame right", {16'd0, got_r}, 32'h00000F0F);

    foreach (vecs[i]) begin
      audio_left  = vecs[i].left;
      audio_right = vecs[i].right;
      mute        = vecs[i].mute;
      gain        = vecs[i].gain;
      capture(-1, 16'h0000, got_l, got_r);
      capture(-1, 16'h0000, got_l, got_r);
      check($sformatf("vec %0d left", i), {16'd0, got_l}, {16'd0, vecs[i].exp_l});
      check($sformatf("vec %0d right", i), {16'd0, got_r}, {16'd0, vecs[i].exp_r});
    end

    // Left input changes at count 100: current frame keeps the old word.
    audio_left  = 16'hA5C3;
    audio_right = 16'h0F0F;
    mute        = 1'b0;
    gain        = 2'd0;
    capture(-1, 16'h0000, got_l, got_r);
    capture(100, 16'h1234, got_l, got_r);
    check("mid-frame change, current left", {16'd0, got_l}, 32'h0000A5C3);
    capture(-1, 16'h0000, got_l, got_r);
    check("mid-frame change, next left", {16'd0, got_l}, 32'h00001234);
    check("mid-frame change, next right", {16'd0, got_r}, 32'h00000F0F);

    // Reset asserted at count 300 aborts the frame.
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("outputs after mid-frame reset", {27'd0, audio_mclk, audio_sck, audio_lrck, sample_req, audio_sdin}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    check_release();
    capture(-1, 16'h0000, got_l, got_r);
    check("frame after mid-frame reset left", {16'd0, got_l}, 32'h00001234);
    check("frame after mid-frame reset right", {16'd0, got_r}, 32'h00000F0F);
    check("sample_req after last frame", {31'd0, sample_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
